tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one UART transmitter (send/din/busy handshake) among NUM_REQ byte requesters.
- Each requester holds a request with its byte. The arbiter grants one requester, drives the transmitter's send/din, and waits for busy to rise and then fall.
- It then acknowledges the requester and rotates priority.
- Sits between protocol/message sources and the single tx instance driving the board's UART pin.

---
 rtl/tx_arbiter.sv | 124 ++++++++++++
 tb/tb_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter (send/din/busy handshake)
// among NUM_REQ byte requesters; acks the winner once its byte has gone out.
module tx_arbiter #(
  parameter  int NUM_REQ       = 4,
  parameter  int START_TIMEOUT = 16,
  localparam int GW            = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_din,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_send,
  output logic [7:0]           tx_din,
  input  logic                 tx_busy,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic                 err
);

  localparam int CW = $clog2(START_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    DONE
  } state_t;

  state_t        state;
  logic [GW-1:0] last;
  logic [CW-1:0] cnt;

  logic          pick_valid;
  logic [GW-1:0] pick_idx;
  logic [7:0]    pick_byte;

  // Scan from the farthest candidate back to last+1 so the nearest
  // asserted requester after the pointer is the one left standing.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave a value held and infer a latch.
  always_comb begin
    logic [GW-1:0] idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last) + k) % NUM_REQ);
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = idx;
      end
    end
    pick_byte = req_din[{pick_idx, 3'b000} +: 8];
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ack      <= '0;
      tx_send  <= 1'b0;
      tx_din   <= 8'h00;
      busy     <= 1'b0;
      grant_id <= '0;
      err      <= 1'b0;
      last     <= GW'(NUM_REQ - 1);
      cnt      <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            tx_din   <= pick_byte;
            tx_send  <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= SEND;
          end
        end

        SEND: begin
          if (tx_busy) begin
            tx_send <= 1'b0;
            state   <= WAIT_DONE;
          end else if (cnt == CW'(START_TIMEOUT - 1)) begin
            // Abandon the grant; the requester keeps req high and competes
            // again from the pointer position after itself.
            tx_send <= 1'b0;
            err     <= 1'b1;
            busy    <= 1'b0;
            last    <= grant_id;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (!tx_busy) begin
            ack[grant_id] <= 1'b1;
            state         <= DONE;
          end
        end

        DONE: begin
          last  <= grant_id;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          tx_send <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: a behavioural tx model plus a scoreboard of
// expected (requester, byte) pairs popped as each ack arrives.
module tb_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int START_TIMEOUT = 16;
  localparam int GW            = $clog2(NUM_REQ);
  localparam int TX_CYC        = 12;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NUM_REQ-1:0]   req = '0;
  logic [8*NUM_REQ-1:0] req_din = '0;
  logic [NUM_REQ-1:0]   ack;
  logic                 tx_send;
  logic [7:0]           tx_din;
  logic                 tx_busy;
  logic                 busy;
  logic [GW-1:0]        grant_id;
  logic                 err;

  tx_arbiter #(.NUM_REQ(NUM_REQ), .START_TIMEOUT(START_TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_din  (req_din),
    .ack      (ack),
    .tx_send  (tx_send),
    .tx_din   (tx_din),
    .tx_busy  (tx_busy),
    .busy     (busy),
    .grant_id (grant_id),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Transmitter model: accepts on send while idle, stays busy TX_CYC clocks,
  // then hands the byte to the receive side.
  logic       tx_dead = 1'b0;
  int         tx_cnt;
  logic [7:0] tx_shift;
  logic [7:0] rx_byte = 8'h00;
  int         rx_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_busy  <= 1'b0;
      tx_cnt   <= 0;
      tx_shift <= 8'h00;
    end else if (tx_busy) begin
      if (tx_cnt == 0) begin
        tx_busy <= 1'b0;
        rx_byte <= tx_shift;
        rx_cnt  <= rx_cnt + 1;
      end else begin
        tx_cnt <= tx_cnt - 1;
      end
    end else if (tx_send && !tx_dead) begin
      tx_busy  <= 1'b1;
      tx_cnt   <= TX_CYC - 1;
      tx_shift <= tx_din;
    end
  end

  typedef struct {
    int         id;
    logic [7:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rx_seen  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic raise(input int id, input logic [7:0] b, input bit expect_it);
    exp_t e;
    req[id] = 1'b1;
    req_din[8*id +: 8] = b;
    if (expect_it) begin
      e.id = id;
      e.b  = b;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_grant(input string tag);
    int k;
    for (k = 0; k < 64; k++) begin
      @(negedge clk);
      if (tx_send) break;
    end
    check({tag, "_grant_seen"}, 32'(k < 64), 32'd1);
  endtask

  // Waits for the next ack, compares it against the scoreboard head, drops
  // the acked requester (plus also_drop) during DONE, then checks the pulse ends.
  task automatic wait_ack(input string tag, input logic [NUM_REQ-1:0] also_drop);
    int   k;
    exp_t e;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (|ack) break;
    end
    check({tag, "_ack_seen"}, 32'(k < 200), 32'd1);
    e = exp_q.pop_front();
    check({tag, "_ack_vec"}, 32'(ack), 32'(1) << e.id);
    check({tag, "_grant_id"}, 32'(grant_id), 32'(e.id));
    check({tag, "_err_low"}, 32'(err), 32'd0);
    check({tag, "_rx_count"}, 32'(rx_cnt), 32'(rx_seen + 1));
    check({tag, "_rx_byte"}, 32'(rx_byte), 32'(e.b));
    rx_seen = rx_cnt;
    req[e.id] = 1'b0;
    req = req & ~also_drop;
    @(negedge clk);
    check({tag, "_ack_one_clk"}, 32'(ack), 32'd0);
  endtask

  initial begin
    int   n;
    logic saw;

    // Reset
    repeat (8) @(negedge clk);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_tx_din", 32'(tx_din), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Single requester
    raise(2, 8'h55, 1'b1);
    @(negedge clk);
    check("single_tx_send", 32'(tx_send), 32'd1);
    check("single_grant_id", 32'(grant_id), 32'd2);
    check("single_tx_din", 32'(tx_din), 32'h55);
    check("single_busy", 32'(busy), 32'd1);
    wait_ack("single", '0);
    check("single_busy_after", 32'(busy), 32'd0);

    // Contention from a fresh pointer: order 0,1,2,3 then 0 again
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    raise(0, 8'hA0, 1'b1);
    raise(1, 8'hA1, 1'b1);
    raise(2, 8'hA2, 1'b1);
    raise(3, 8'hA3, 1'b1);
    wait_grant("cont");
    check("cont_first_grant", 32'(grant_id), 32'd0);
    wait_ack("cont0", '0);
    raise(0, 8'hB0, 1'b1);
    wait_ack("cont1", '0);
    wait_ack("cont2", '0);
    wait_ack("cont3", '0);
    wait_ack("cont0b", '0);

    // Start timeout with a dead transmitter
    tx_dead = 1'b1;
    raise(1, 8'h11, 1'b0);
    wait_grant("tmo");
    check("tmo_grant_id", 32'(grant_id), 32'd1);
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (err) break;
    end
    check("tmo_cycles", 32'(n), 32'(START_TIMEOUT));
    check("tmo_no_ack", 32'(ack), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_tx_send", 32'(tx_send), 32'd0);
    @(negedge clk);
    check("tmo_err_one_clk", 32'(err), 32'd0);
    check("tmo_regrant", 32'(tx_send), 32'd1);
    check("tmo_regrant_id", 32'(grant_id), 32'd1);
    tx_dead = 1'b0;
    raise(1, 8'h11, 1'b1);
    wait_ack("tmo_retry", '0);

    // Reset in the middle of a transfer
    raise(0, 8'hA5, 1'b0);
    wait_grant("mid");
    check("mid_grant_id", 32'(grant_id), 32'd0);
    check("mid_tx_din", 32'(tx_din), 32'hA5);
    repeat (8) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_tx_send", 32'(tx_send), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    req[0] = 1'b0;
    #19;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_post_tx_send", 32'(tx_send), 32'd0);
    check("mid_post_busy", 32'(busy), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      saw = saw | (|ack);
    end
    check("mid_no_ack", 32'(saw), 32'd0);
    check("mid_no_rx", 32'(rx_cnt), 32'(rx_seen));
    raise(3, 8'h3C, 1'b1);
    wait_grant("mid_next");
    check("mid_next_grant", 32'(grant_id), 32'd3);
    wait_ack("mid_next", '0);

    // Withdrawal: 1 and 2 arrive during WAIT_DONE, 1 drops before DONE ends
    raise(0, 8'h0F, 1'b1);
    for (n = 0; n < 64; n++) begin
      @(negedge clk);
      if (tx_busy && !tx_send) break;
    end
    check("wd_in_wait_done", 32'(n < 64), 32'd1);
    raise(1, 8'h21, 1'b0);
    raise(2, 8'h22, 1'b1);
    wait_ack("wd0", 4'b0010);
    wait_grant("wd");
    check("wd_grant_id", 32'(grant_id), 32'd2);
    wait_ack("wd2", '0);
    repeat (4) @(negedge clk);
    check("wd_idle_busy", 32'(busy), 32'd0);
    check("wd_idle_ack", 32'(ack), 32'd0);
    check("wd_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
